// File: rtl/mul_share_pkg.sv
// Shared constants and the FSM state type for the multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int OPW = 8;   // operand width
    localparam int PW  = 16;  // product width

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        RESP = ST_RESP
    } state_e;

endpackage

// File: rtl/mul_share_arbiter_rr_grant.sv
// Combinational round-robin picker: searches upward from the requester after
// last_grant, wrapping modulo NREQ, and returns the first active request.
module rr_grant #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic [NREQ-1:0] grant_oh_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            any_o
);

    int              cand;
    logic [NREQ-1:0] shifted;

    // Walk candidates last+1 .. last+NREQ; the first one found wins.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = 0;
        shifted     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand    = (int'(last_grant_i) + k) % NREQ;
            shifted = req_i >> cand;
            if (!any_o && shifted[0]) begin
                any_o       = 1'b1;
                grant_oh_o  = NREQ'(1) << cand;
                grant_idx_o = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/multiplier_8bit.sv
// Plain combinational unsigned 8x8 -> 16 multiplier shared by all requesters.
module multiplier_8bit (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] MulResult
);

    assign MulResult = {8'd0, A} * {8'd0, B};

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one combinational multiplier among NREQ valid/ready requesters.
// IDLE grants round-robin, CALC registers the product, RESP holds the
// tagged response until the consumer takes it.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [OPW-1:0]  op_a_q, op_a_d;
    logic [OPW-1:0]  op_b_q, op_b_d;
    logic [PW-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [PW-1:0]   mul_result;

    // AND-OR operand mux chains; grant_oh is one-hot so at most one term is live.
    logic [OPW-1:0]  acc_a [NREQ+1];
    logic [OPW-1:0]  acc_b [NREQ+1];

    assign acc_a[0] = '0;
    assign acc_b[0] = '0;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_opmux
            assign acc_a[gi+1] = acc_a[gi] | (req_a[gi*OPW +: OPW] & {OPW{grant_oh[gi]}});
            assign acc_b[gi+1] = acc_b[gi] | (req_b[gi*OPW +: OPW] & {OPW{grant_oh[gi]}});
        end
    endgenerate

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (grant_oh),
        .grant_idx_o  (grant_idx),
        .any_o        (grant_any)
    );

    multiplier_8bit u_mul (
        .A         (op_a_q),
        .B         (op_b_q),
        .MulResult (mul_result)
    );

    // Next-state and datapath updates; req_ready is only ever raised in IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                // The granted requester is valid by construction, so an
                // active grant is always a completed handshake.
                if (grant_any) begin
                    req_ready    = grant_oh;
                    op_a_d       = acc_a[NREQ];
                    op_b_d       = acc_b[NREQ];
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = CALC;
                end
            end
            CALC: begin
                rsp_data_d  = mul_result;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Data and id stay put after the handshake; only valid drops.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset discards any in-flight product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= IDW'(NREQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter with two requesters.
module tb_mul_share_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    mul_share_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One complete transaction from a single requester with rsp_ready held high.
    task automatic do_txn(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string tag);
        int waited;
        @(negedge clk);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid = NREQ'(1) << id;
        rsp_ready = 1'b1;
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (req_ready == '0) begin
            checks++;
            errors++;
            $display("FAIL %s_grant_timeout: got ready=0 expected a grant", tag);
            req_valid = '0;
            return;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk({tag, "_calc_busy"}, 32'(busy), 32'd1);
        chk({tag, "_calc_nvalid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_calc_nready"}, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp));
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_rsp_busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_nvalid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_nbusy"}, 32'(busy), 32'd0);
        $display("txn %s: req%0d %0d*%0d -> %0d", tag, id, a, b, exp);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] both_exp [2];

        vecs[0] = '{0, 8'd15,  8'd2,   16'd30};
        vecs[1] = '{0, 8'd255, 8'd1,   16'd255};
        vecs[2] = '{1, 8'd0,   8'd200, 16'd0};
        vecs[3] = '{1, 8'd1,   8'd1,   16'd1};
        vecs[4] = '{1, 8'd255, 8'd255, 16'd65025};
        vecs[5] = '{0, 8'd16,  8'd16,  16'd256};

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single-requester transactions
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Both requesters continuously valid: grants alternate starting at 0
        pulse_reset();
        both_exp[0] = 16'd14450;
        both_exp[1] = 16'd65025;
        req_a = {8'd255, 8'd170};
        req_b = {8'd255, 8'd85};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(posedge clk);
            #1;
            chk("both_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (rsp_valid) begin
                chk($sformatf("both_data%0d", k), 32'(rsp_data), 32'(both_exp[k % 2]));
                chk($sformatf("both_id%0d", k), 32'(rsp_id), 32'(k % 2));
                $display("txn both%0d: id=%0d data=%0d", k, rsp_id, rsp_data);
                k++;
            end
        end
        req_valid = '0;
        if (k < 4) begin
            checks++;
            errors++;
            $display("FAIL both_timeout: got %0d responses expected 4", k);
        end
        @(posedge clk);
        #1;
        chk("both_idle_busy", 32'(busy), 32'd0);

        // Backpressure; req1 waits during the stall and changes its operands
        @(negedge clk);
        req_a[7:0] = 8'd128;
        req_b[7:0] = 8'd128;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_a[15:8] = 8'd99;
        req_b[15:8] = 8'd99;
        req_valid = 2'b10;
        chk("bp_calc_nready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_stall_valid", 32'(rsp_valid), 32'd1);
            chk("bp_stall_data", 32'(rsp_data), 32'd16384);
            chk("bp_stall_id", 32'(rsp_id), 32'd0);
            chk("bp_stall_nready", 32'(req_ready), 32'd0);
            if (i == 2) begin
                req_a[15:8] = 8'd10;
                req_b[15:8] = 8'd20;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_still_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done_nvalid", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant1", 32'(req_ready), 32'd2);
        $display("txn bp: 128*128 -> 16384 after stall");
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("late_op_data", 32'(rsp_data), 32'd200);
        chk("late_op_id", 32'(rsp_id), 32'd1);
        $display("txn late_op: req1 10*20 -> %0d", rsp_data);
        @(posedge clk);
        #1;

        // Reset in CALC discards the product
        @(negedge clk);
        req_a[7:0] = 8'd255;
        req_b[7:0] = 8'd255;
        req_valid = 2'b01;
        #1;
        chk("rc_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("rc_calc_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rc_rsp_data", 32'(rsp_data), 32'd0);
        chk("rc_rsp_id", 32'(rsp_id), 32'd0);
        chk("rc_busy", 32'(busy), 32'd0);
        chk("rc_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rc_no_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("txn reset_calc: product discarded");
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rc_last_grant_reset", 32'(req_ready), 32'd1);
        req_valid = '0;
        do_txn(1, 8'd7, 8'd9, 16'd63, "rc_after");

        // Reset in RESP drops the pending response
        @(negedge clk);
        req_a[15:8] = 8'd3;
        req_b[15:8] = 8'd5;
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("rr_pre_valid", 32'(rsp_valid), 32'd1);
        chk("rr_pre_data", 32'(rsp_data), 32'd15);
        rst = 1'b1;
        #1;
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rr_rsp_data", 32'(rsp_data), 32'd0);
        chk("rr_rsp_id", 32'(rsp_id), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset_resp: response dropped");

        // Idle gap, then arrivals one at a time and grant order afterwards
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_quiet", 32'({busy, req_ready, rsp_valid}), 32'd0);
        end
        do_txn(1, 8'd12, 8'd12, 16'd144, "gap_req1");
        do_txn(0, 8'd9, 8'd9, 16'd81, "gap_req0");
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("gap_next_grant", 32'(req_ready), 32'd2);
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
